// File: rtl/fsmprob_driver.sv
// Initiator-side driver for the four-state i/j Moore controller: walks it to requested targets and checks x/y against a shadow copy.
// Optional build macro FSMDRV_RESYNC_EN: reload the shadow from an unambiguous x/y instead of faulting.
module fsmprob_driver #(
    parameter int MAX_STEPS = 4
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic       req_valid,
    input  logic [1:0] req_target,
    output logic       req_ready,
    output logic       done,
    output logic       i,
    output logic       j,
    input  logic       x,
    input  logic       y,
    output logic       err,
    output logic [1:0] shadow
);

    localparam int STEP_W = $clog2(MAX_STEPS + 1);

    localparam logic [1:0] ST_A = 2'b00;
    localparam logic [1:0] ST_B = 2'b01;
    localparam logic [1:0] ST_C = 2'b10;
    localparam logic [1:0] ST_D = 2'b11;

    localparam logic [1:0] DRV_IDLE  = 2'b00;
    localparam logic [1:0] DRV_RUN   = 2'b01;
    localparam logic [1:0] DRV_FAULT = 2'b10;

    function automatic logic [1:0] expected_xy(input logic [1:0] st);
        case (st)
            ST_A:    expected_xy = 2'b11;
            ST_B:    expected_xy = 2'b01;
            ST_C:    expected_xy = 2'b10;
            default: expected_xy = 2'b10;
        endcase
    endfunction

    function automatic logic [1:0] next_shadow(input logic [1:0] st, input logic [1:0] ij);
        case (st)
            ST_A:    next_shadow = ij[1] ? ST_B : ST_A;
            ST_B:    next_shadow = ij[0] ? ST_C : ST_D;
            ST_C:    next_shadow = ij[1] ? ST_B : (ij[0] ? ST_C : ST_D);
            default: next_shadow = ij[1] ? ST_D : (ij[0] ? ST_C : ST_A);
        endcase
    endfunction

    // B has no self-loop, so its hold drive deliberately moves on to C.
    function automatic logic [1:0] hold_drive(input logic [1:0] st);
        case (st)
            ST_A:    hold_drive = 2'b00;
            ST_B:    hold_drive = 2'b01;
            ST_C:    hold_drive = 2'b01;
            default: hold_drive = 2'b10;
        endcase
    endfunction

    function automatic logic [1:0] route_drive(input logic [1:0] tgt, input logic [1:0] st);
        case (tgt)
            ST_A:    route_drive = 2'b00;
            ST_B:    route_drive = (st == ST_D) ? 2'b01 : 2'b10;
            ST_C:    route_drive = (st == ST_A) ? 2'b10 : 2'b01;
            default: route_drive = (st == ST_A) ? 2'b10 : 2'b00;
        endcase
    endfunction

    logic [1:0]        drv_q, drv_d;
    logic [1:0]        shadow_q, shadow_d;
    logic [1:0]        target_q, target_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              err_q, err_d;
    logic [1:0]        drive_s;
    logic              done_s;
    logic              diverge_s;

    assign diverge_s = ({x, y} != expected_xy(shadow_q));

    // Next-state, drive and divergence handling.
    always_comb begin
        drive_s  = 2'b00;
        done_s   = 1'b0;
        drv_d    = drv_q;
        target_d = target_q;
        step_d   = step_q;
        err_d    = err_q;
        case (drv_q)
            DRV_IDLE: begin
                drive_s = hold_drive(shadow_q);
                if (req_valid) begin
                    drv_d    = DRV_RUN;
                    target_d = req_target;
                    step_d   = {STEP_W{1'b0}};
                end else begin
                    drv_d    = DRV_IDLE;
                end
            end
            DRV_RUN: begin
                if (shadow_q == target_q) begin
                    done_s  = 1'b1;
                    drive_s = hold_drive(shadow_q);
                    drv_d   = DRV_IDLE;
                end else if (step_q >= STEP_W'(MAX_STEPS)) begin
                    drv_d   = DRV_FAULT;
                    err_d   = 1'b1;
                end else begin
                    drive_s = route_drive(target_q, shadow_q);
                    step_d  = step_q + {{(STEP_W-1){1'b0}}, 1'b1};
                end
            end
            DRV_FAULT: begin
                drv_d = DRV_FAULT;
            end
            default: begin
                drv_d = DRV_FAULT;
                err_d = 1'b1;
            end
        endcase

        shadow_d = next_shadow(shadow_q, drive_s);

        if (diverge_s && (drv_q != DRV_FAULT)) begin
            err_d = 1'b1;
`ifdef FSMDRV_RESYNC_EN
            if ({x, y} == 2'b11) begin
                shadow_d = ST_A;
            end else if ({x, y} == 2'b01) begin
                shadow_d = ST_B;
            end else begin
                drv_d = DRV_FAULT;
            end
`else
            drv_d = DRV_FAULT;
`endif
        end else begin
            err_d = err_d;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            drv_q    <= DRV_IDLE;
            shadow_q <= ST_A;
            target_q <= ST_A;
            step_q   <= {STEP_W{1'b0}};
            err_q    <= 1'b0;
        end else begin
            drv_q    <= drv_d;
            shadow_q <= shadow_d;
            target_q <= target_d;
            step_q   <= step_d;
            err_q    <= err_d;
        end
    end

    assign req_ready = (drv_q == DRV_IDLE);
    assign done      = done_s;
    assign i         = drive_s[1];
    assign j         = drive_s[0];
    assign err       = err_q;
    assign shadow    = shadow_q;

endmodule

// File: tb/tb_fsmprob_driver.sv
// Bench for fsmprob_driver: a table-driven controller model closes the loop, a reference model is compared every cycle.
module tb_fsmprob_driver;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_target = 2'b00;
    logic       req_ready, done, i, j, x, y, err;
    logic [1:0] shadow;

    fsmprob_driver #(.MAX_STEPS(4)) dut (
        .clk(clk), .rstN(rstN), .req_valid(req_valid), .req_target(req_target),
        .req_ready(req_ready), .done(done), .i(i), .j(j), .x(x), .y(y),
        .err(err), .shadow(shadow)
    );

    always #5 clk = ~clk;

    // Controller transition table [state][{i,j}], expected x/y, hold drive, route drive [target][state].
    logic [1:0] nxt_tab [4][4] = '{'{2'd0, 2'd0, 2'd1, 2'd1},
                                   '{2'd3, 2'd2, 2'd3, 2'd2},
                                   '{2'd3, 2'd2, 2'd1, 2'd1},
                                   '{2'd0, 2'd2, 2'd3, 2'd3}};
    logic [1:0] xy_tab [4]       = '{2'b11, 2'b01, 2'b10, 2'b10};
    logic [1:0] hold_tab [4]     = '{2'b00, 2'b01, 2'b01, 2'b10};
    logic [1:0] route_tab [4][4] = '{'{2'b00, 2'b00, 2'b00, 2'b00},
                                     '{2'b10, 2'b00, 2'b10, 2'b01},
                                     '{2'b10, 2'b01, 2'b00, 2'b01},
                                     '{2'b10, 2'b00, 2'b00, 2'b00}};

    // Environment: the controller itself, with an x/y override for fault injection.
    logic [1:0] ctl;
    logic       force_en = 1'b0;
    logic [1:0] force_xy = 2'b00;
    always @(posedge clk) begin
        if (!rstN) ctl <= 2'd0;
        else       ctl <= nxt_tab[ctl][{i, j}];
    end
    assign {x, y} = force_en ? force_xy : xy_tab[ctl];

    // Reference model: mode 0 idle, 1 run, 2 fault.
    int         m_mode, n_mode;
    logic [1:0] m_sh, n_sh, m_tg, n_tg, e_ij;
    logic       m_err, n_err, e_done, e_ready, div;

    always_comb begin
        e_ij = hold_tab[m_sh];
        if (m_mode == 2) e_ij = 2'b00;
        else if (m_mode == 1 && m_sh != m_tg) e_ij = route_tab[m_tg][m_sh];
        e_done  = (m_mode == 1) && (m_sh == m_tg);
        e_ready = (m_mode == 0);
        div     = ({x, y} != xy_tab[m_sh]);
        n_sh = nxt_tab[m_sh][e_ij];
        n_mode = m_mode;
        n_tg = m_tg;
        n_err = m_err;
        if (m_mode == 0 && req_valid) begin
            n_mode = 1;
            n_tg   = req_target;
        end
        if (e_done) n_mode = 0;
        if (div && m_mode != 2) begin
            n_err = 1'b1;
`ifdef FSMDRV_RESYNC_EN
            if ({x, y} == 2'b11) n_sh = 2'd0;
            else if ({x, y} == 2'b01) n_sh = 2'd1;
            else n_mode = 2;
`else
            n_mode = 2;
`endif
        end
    end

    always @(posedge clk) begin
        if (!rstN) begin
            m_mode <= 0; m_sh <= 2'd0; m_tg <= 2'd0; m_err <= 1'b0;
        end else begin
            m_mode <= n_mode; m_sh <= n_sh; m_tg <= n_tg; m_err <= n_err;
        end
    end

    int chk_cnt = 0;
    int pass_cnt = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_ij", {6'd0, i, j}, {6'd0, e_ij});
            chk("cyc_done", {7'd0, done}, {7'd0, e_done});
            chk("cyc_ready", {7'd0, req_ready}, {7'd0, e_ready});
            chk("cyc_err", {7'd0, err}, {7'd0, m_err});
            chk("cyc_shadow", {6'd0, shadow}, {6'd0, m_sh});
        end
    end

    task automatic do_reset();
        @(negedge clk) rstN = 1'b0;
        @(negedge clk) rstN = 1'b0;
        @(negedge clk) rstN = 1'b1;
    endtask

    task automatic send(input logic [1:0] tg, input int exp_lat, input logic [1:0] exp_sh,
                        input logic [1:0] ij1, input logic [1:0] ij2, input logic [1:0] sh_after);
        int n;
        logic [1:0] first_ij, second_ij;
        @(negedge clk);
        req_valid = 1'b1; req_target = tg;
        @(negedge clk);
        req_valid = 1'b0; req_target = ~tg;
        n = 1;
        first_ij = {i, j};
        second_ij = 2'b00;
        while (!done && n < 12) begin
            @(negedge clk);
            n++;
            if (n == 2) second_ij = {i, j};
        end
        chk("latency", 8'(n), 8'(exp_lat));
        chk("done_shadow", {6'd0, shadow}, {6'd0, exp_sh});
        chk("run_ij1", {6'd0, first_ij}, {6'd0, ij1});
        if (exp_lat > 2) chk("run_ij2", {6'd0, second_ij}, {6'd0, ij2});
        @(negedge clk);
        chk("ready_after", {7'd0, req_ready}, 8'd1);
        chk("shadow_after", {6'd0, shadow}, {6'd0, sh_after});
    endtask

    initial begin
        do_reset();
        chk_en = 1'b1;
        chk("rst_ready", {7'd0, req_ready}, 8'd1);
        chk("rst_ij", {6'd0, i, j}, 8'd0);
        chk("rst_shadow", {6'd0, shadow}, 8'd0);
        chk("rst_err", {7'd0, err}, 8'd0);
        chk("rst_done", {7'd0, done}, 8'd0);

        send(2'd0, 1, 2'd0, 2'b00, 2'b00, 2'd0);  // A -> A
        send(2'd3, 3, 2'd3, 2'b10, 2'b00, 2'd3);  // A -> D
        send(2'd1, 3, 2'd1, 2'b01, 2'b10, 2'd2);  // D -> B, hold then moves to C
        send(2'd0, 3, 2'd0, 2'b00, 2'b00, 2'd0);  // C -> A

        // Divergence in IDLE with shadow A.
        force_en = 1'b1; force_xy = 2'b01;
        @(negedge clk);
        force_en = 1'b0;
        chk("div_err", {7'd0, err}, 8'd1);
`ifdef FSMDRV_RESYNC_EN
        chk("div_ready", {7'd0, req_ready}, 8'd1);
        chk("div_shadow", {6'd0, shadow}, 8'd1);
`else
        chk("div_ready", {7'd0, req_ready}, 8'd0);
        chk("div_ij", {6'd0, i, j}, 8'd0);
`endif
        repeat (3) @(negedge clk);

        // Reset during the first RUN step toward D.
        do_reset();
        req_valid = 1'b1; req_target = 2'd3;
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid_ij", {6'd0, i, j}, 8'b10);
        chk("mid_done", {7'd0, done}, 8'd0);
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        chk("mid_rst_ready", {7'd0, req_ready}, 8'd1);
        chk("mid_rst_shadow", {6'd0, shadow}, 8'd0);
        chk("mid_rst_done", {7'd0, done}, 8'd0);
        chk("mid_rst_err", {7'd0, err}, 8'd0);
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
